// File: rtl/ldd_pkg.sv
// Shared definitions for the laser-driver write-disable controller:
// mode encodings, per-channel FSM states and counter sizing helper.
package ldd_pkg;

  typedef enum logic [1:0] {
    MODE_COM  = 2'b00,
    MODE_CAP  = 2'b01,
    MODE_FOFF = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_ARM  = 2'b01,
    ST_ON   = 2'b10,
    ST_HOLD = 2'b11
  } ch_state_e;

  // Bits needed to count 0 .. max(a,b)-1, never less than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/OBUFDS.sv
// Behavioural stand-in for the vendor differential output buffer, used for
// simulation and lint only; the vendor library cell replaces it in the build.
module OBUFDS #(
  parameter string IOSTANDARD = "DEFAULT",
  parameter string SLEW       = "SLOW"
) (
  output logic O,
  output logic OB,
  input  logic I
);

  // Parameters only steer the real pad cell; referenced here so they are visible.
  if (IOSTANDARD == "" || SLEW == "") begin : g_unset_attr
  end

  assign O  = I;
  assign OB = ~I;

endmodule

// File: rtl/ldd_wdis_ch.sv
// One write-disable channel: OFF/ARM/ON/HOLD sequencer with a shared
// arm/hold counter and the registered laser drive bit (1 = laser enabled).
module ldd_wdis_ch
  import ldd_pkg::*;
#(
  parameter int ARM_CYC  = 200,
  parameter int HOLD_CYC = 400
) (
  input  logic clk200,
  input  logic rst,
  input  logic en_req_i,
  output logic drive_o,
  output logic arm_busy_o
);

  localparam int            CW        = cnt_width(ARM_CYC, HOLD_CYC);
  localparam logic [CW-1:0] ARM_LAST  = CW'(ARM_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);

  ch_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic          drive_q;

  // Sequencer; the drive bit is written on the same edge as the state that owns it.
  always_ff @(posedge clk200) begin
    if (rst) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      drive_q <= 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          drive_q <= 1'b0;
          if (en_req_i) begin
            state_q <= ST_ARM;
            cnt_q   <= '0;
          end
        end
        ST_ARM: begin
          if (!en_req_i) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
          end else if (cnt_q == ARM_LAST) begin
            state_q <= ST_ON;
            cnt_q   <= '0;
            drive_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_ON: begin
          if (!en_req_i) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            drive_q <= 1'b0;
          end
        end
        ST_HOLD: begin
          // Minimum off time: requests are ignored until the hold expires.
          drive_q <= 1'b0;
          if (cnt_q == HOLD_LAST) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_OFF;
          cnt_q   <= '0;
          drive_q <= 1'b0;
        end
      endcase
    end
  end

  assign drive_o    = drive_q;
  assign arm_busy_o = (state_q == ST_ARM) || (state_q == ST_HOLD);

endmodule

// File: rtl/ldd_wdis_ctrl.sv
// Laser-driver write-disable controller: input capture, enable qualification
// (mode, watchdog, mode-change blanking), per-channel sequencers, status and pads.
module ldd_wdis_ctrl
  import ldd_pkg::*;
#(
  parameter int N_CH     = 3,
  parameter int ARM_CYC  = 200,
  parameter int HOLD_CYC = 400,
  parameter int WDOG_CYC = 2000000
) (
  input  logic            clk200,
  input  logic            rst,
  input  logic [1:0]      mode,
  input  logic [N_CH-1:0] cap_wdis,
  input  logic [N_CH-1:0] com_wdis,
  input  logic            com_kick,
  input  logic            wdog_clr,
  output logic [N_CH-1:0] wdis_out,
  output logic [N_CH-1:0] arm_busy,
  output logic            wdog_trip,
  output logic [N_CH-1:0] ldd_wp,
  output logic [N_CH-1:0] ldd_wn
);

  localparam int            WW        = cnt_width(WDOG_CYC, 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYC - 1);

  mode_e           mode_r_q;
  mode_e           mode_prev_q;
  logic [N_CH-1:0] wdis_sel_q;
  logic [N_CH-1:0] en_req_d;
  logic [N_CH-1:0] en_req_q;
  logic            en_ok;
  logic [WW-1:0]   wcnt_q;
  logic            trip_q;
  logic [N_CH-1:0] drive;
  logic [N_CH-1:0] wdis_out_q;

  // Stage 0: capture mode and the request vector selected by the incoming mode.
  always_ff @(posedge clk200) begin
    if (rst) begin
      mode_r_q    <= MODE_FOFF;
      mode_prev_q <= MODE_FOFF;
      wdis_sel_q  <= '1;
    end else begin
      mode_r_q    <= mode_e'(mode);
      mode_prev_q <= mode_r_q;
      wdis_sel_q  <= (mode_e'(mode) == MODE_CAP) ? cap_wdis : com_wdis;
    end
  end

  // Enable only in COM/CAP, never while tripped, and never in the cycle the mode changes.
  always_comb begin
    en_ok    = ((mode_r_q == MODE_COM) || (mode_r_q == MODE_CAP)) &&
               !trip_q && (mode_r_q == mode_prev_q);
    en_req_d = ~wdis_sel_q & {N_CH{en_ok}};
  end

  // Stage 1: register the qualified enable that the channel sequencers act on.
  always_ff @(posedge clk200) begin
    if (rst) begin
      en_req_q <= '0;
    end else begin
      en_req_q <= en_req_d;
    end
  end

  // COM watchdog: counts while in COM, a kick beats a same-cycle expiry, trip is sticky.
  always_ff @(posedge clk200) begin
    if (rst) begin
      wcnt_q <= '0;
      trip_q <= 1'b0;
    end else begin
      if (mode_r_q != MODE_COM || com_kick || wcnt_q == WDOG_LAST) begin
        wcnt_q <= '0;
      end else begin
        wcnt_q <= wcnt_q + 1'b1;
      end
      if (wdog_clr) begin
        trip_q <= 1'b0;
      end else if (mode_r_q == MODE_COM && !com_kick && wcnt_q == WDOG_LAST) begin
        trip_q <= 1'b1;
      end
    end
  end

  // Stage 2: per-channel sequencers and differential pads.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ldd_wdis_ch #(
      .ARM_CYC  (ARM_CYC),
      .HOLD_CYC (HOLD_CYC)
    ) u_ch (
      .clk200     (clk200),
      .rst        (rst),
      .en_req_i   (en_req_q[g]),
      .drive_o    (drive[g]),
      .arm_busy_o (arm_busy[g])
    );

    OBUFDS #(
      .SLEW ("SLOW")
    ) u_obuf (
      .O  (ldd_wp[g]),
      .OB (ldd_wn[g]),
      .I  (drive[g])
    );
  end

  // Stage 3: status copy of the drive, one register behind it.
  always_ff @(posedge clk200) begin
    if (rst) begin
      wdis_out_q <= '1;
    end else begin
      wdis_out_q <= ~drive;
    end
  end

  assign wdis_out  = wdis_out_q;
  assign wdog_trip = trip_q;

endmodule

// File: tb/tb_ldd_wdis_ctrl.sv
// Directed bench for ldd_wdis_ctrl with N_CH=3, ARM_CYC=8, HOLD_CYC=16, WDOG_CYC=100.
module tb_ldd_wdis_ctrl;

  localparam int N_CH = 3;

  logic            clk200 = 1'b0;
  logic            rst;
  logic [1:0]      mode;
  logic [N_CH-1:0] cap_wdis;
  logic [N_CH-1:0] com_wdis;
  logic            com_kick;
  logic            wdog_clr;
  logic [N_CH-1:0] wdis_out;
  logic [N_CH-1:0] arm_busy;
  logic            wdog_trip;
  logic [N_CH-1:0] ldd_wp;
  logic [N_CH-1:0] ldd_wn;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc;

  ldd_wdis_ctrl #(
    .N_CH     (N_CH),
    .ARM_CYC  (8),
    .HOLD_CYC (16),
    .WDOG_CYC (100)
  ) dut (
    .clk200    (clk200),
    .rst       (rst),
    .mode      (mode),
    .cap_wdis  (cap_wdis),
    .com_wdis  (com_wdis),
    .com_kick  (com_kick),
    .wdog_clr  (wdog_clr),
    .wdis_out  (wdis_out),
    .arm_busy  (arm_busy),
    .wdog_trip (wdog_trip),
    .ldd_wp    (ldd_wp),
    .ldd_wn    (ldd_wn)
  );

  always #5 clk200 = ~clk200;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk200);
      #1;
    end
  endtask

  initial begin
    rst      = 1'b1;
    mode     = 2'b10;
    cap_wdis = 3'b111;
    com_wdis = 3'b111;
    com_kick = 1'b0;
    wdog_clr = 1'b0;
    tick(3);

    // Reset state
    chk_eq("rst_wdis_out", wdis_out, 3'b111);
    chk_eq("rst_arm_busy", arm_busy, 3'b000);
    chk_eq("rst_trip", wdog_trip, 1'b0);
    chk_eq("rst_wp", ldd_wp, 3'b000);
    chk_eq("rst_wn", ldd_wn, 3'b111);

    rst  = 1'b0;
    mode = 2'b01;
    tick(5);
    chk_eq("cap_idle_wp", ldd_wp, 3'b000);

    // CAP enable of ch0: ARM at k+2, drive high at k+10
    cap_wdis = 3'b110;
    tick(3);
    chk_eq("en_arm_busy", arm_busy, 3'b001);
    tick(7);
    chk_eq("en_wp_k9", ldd_wp, 3'b000);
    tick(1);
    chk_eq("en_wp_k10", ldd_wp, 3'b001);
    chk_eq("en_wn_k10", ldd_wn, 3'b110);
    chk_eq("en_busy_on", arm_busy, 3'b000);
    tick(1);
    chk_eq("en_wdis_out", wdis_out, 3'b110);

    // One-cycle disable pulse on ch0: drive low at j+2, HOLD 16, re-ARM 8
    cap_wdis = 3'b111;
    tick(1);
    cap_wdis = 3'b110;
    tick(1);
    chk_eq("dis_wp_j1", ldd_wp, 3'b001);
    tick(1);
    chk_eq("dis_wp_j2", ldd_wp, 3'b000);
    chk_eq("dis_busy_j2", arm_busy, 3'b001);
    chk_eq("dis_wdis_out_j2", wdis_out, 3'b110);
    tick(1);
    chk_eq("dis_wdis_out_j3", wdis_out, 3'b111);
    tick(14);
    chk_eq("hold_busy_j17", arm_busy, 3'b001);
    chk_eq("hold_wp_j17", ldd_wp, 3'b000);
    tick(2);
    chk_eq("rearm_busy_j19", arm_busy, 3'b001);
    tick(7);
    chk_eq("rearm_wp_j26", ldd_wp, 3'b000);
    tick(1);
    chk_eq("rearm_wp_j27", ldd_wp, 3'b001);
    chk_eq("rearm_busy_j27", arm_busy, 3'b000);

    // ch1 enable withdrawn while arming: back to OFF, never driven
    cap_wdis = 3'b100;
    tick(5);
    chk_eq("abort_busy", arm_busy, 3'b010);
    cap_wdis = 3'b110;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk_eq("abort_wp", ldd_wp, 3'b001);
    end
    chk_eq("abort_busy_off", arm_busy, 3'b000);

    // COM mode, no kicks: trip 100 cycles after mode_r becomes COM
    com_wdis = 3'b000;
    mode     = 2'b00;
    cyc      = 0;
    while (!wdog_trip && cyc < 200) begin
      tick(1);
      cyc++;
      if (cyc == 60) chk_eq("com_all_on", ldd_wp, 3'b111);
    end
    chk_eq("wdog_latency", cyc, 101);
    tick(2);
    chk_eq("trip_wp", ldd_wp, 3'b000);
    chk_eq("trip_sticky", wdog_trip, 1'b1);
    tick(1);
    chk_eq("trip_wdis_out", wdis_out, 3'b111);
    tick(20);
    chk_eq("trip_busy_off", arm_busy, 3'b000);
    chk_eq("trip_still", wdog_trip, 1'b1);

    // wdog_clr (with a kick) re-arms all channels
    wdog_clr = 1'b1;
    com_kick = 1'b1;
    tick(1);
    wdog_clr = 1'b0;
    com_kick = 1'b0;
    chk_eq("clr_trip", wdog_trip, 1'b0);
    tick(9);
    chk_eq("clr_wp_c9", ldd_wp, 3'b000);
    chk_eq("clr_busy_c9", arm_busy, 3'b111);
    tick(1);
    chk_eq("clr_wp_c10", ldd_wp, 3'b111);
    for (int i = 0; i < 150; i++) begin
      com_kick = (i % 40 == 0);
      tick(1);
    end
    com_kick = 1'b0;
    chk_eq("kick_no_trip", wdog_trip, 1'b0);
    chk_eq("kick_wp", ldd_wp, 3'b111);

    // COM -> CAP with the same requests: HOLD, ARM, ON
    cap_wdis = 3'b000;
    mode     = 2'b01;
    tick(3);
    chk_eq("mchg_wp_p2", ldd_wp, 3'b000);
    chk_eq("mchg_busy_p2", arm_busy, 3'b111);
    tick(17);
    chk_eq("mchg_busy_p19", arm_busy, 3'b111);
    chk_eq("mchg_wp_p19", ldd_wp, 3'b000);
    tick(8);
    chk_eq("mchg_wp_p27", ldd_wp, 3'b111);
    chk_eq("mchg_trip", wdog_trip, 1'b0);

    // Reset pulse while channels are ON
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_eq("rstp_wp", ldd_wp, 3'b000);
    chk_eq("rstp_wdis_out", wdis_out, 3'b111);
    chk_eq("rstp_busy", arm_busy, 3'b000);
    tick(1);
    chk_eq("rstp_wdis_out_n1", wdis_out, 3'b111);
    chk_eq("rstp_busy_n1", arm_busy, 3'b000);
    chk_eq("rstp_wp_n1", ldd_wp, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
